// File: rtl/nx_egress_pkg.sv
// Shared types and defaults for the egress aggregator at the south edge of the mesh.
package nx_egress_pkg;

  localparam int unsigned NX_EG_STREAM_WIDTH = 32;
  localparam int unsigned NX_EG_COLUMNS      = 4;
  localparam int unsigned NX_EG_FIFO_DEPTH   = 8;
  localparam int unsigned NX_EG_COUNT_WIDTH  = 16;
  localparam int unsigned NX_EG_COL_WIDTH    = $clog2(NX_EG_COLUMNS);

  // Buffered message: source column tag plus untouched payload.
  typedef struct packed {
    logic [NX_EG_COL_WIDTH-1:0]    col;
    logic [NX_EG_STREAM_WIDTH-1:0] data;
  } nx_eg_entry_t;

  function automatic int unsigned nx_eg_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/nx_egress_fifo.sv
// First-word-fall-through FIFO with synchronous flush and wrap-bit pointers.
module nx_egress_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_level   = r_wr - r_rd;
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  // Empty head reads as zero so the host bus is clean out of reset.
  assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/nx_egress_aggregator.sv
// Round-robin merge of the bottom-row south streams into one column-tagged host stream.
module nx_egress_aggregator
  import nx_egress_pkg::*;
#(
  parameter int unsigned STREAM_WIDTH = NX_EG_STREAM_WIDTH,
  parameter int unsigned COLUMNS      = NX_EG_COLUMNS,
  parameter int unsigned FIFO_DEPTH   = NX_EG_FIFO_DEPTH,
  parameter int unsigned COUNT_WIDTH  = NX_EG_COUNT_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic                              flush_i,
  input  logic [COLUMNS*STREAM_WIDTH-1:0]   ib_data_i,
  input  logic [COLUMNS-1:0]                ib_valid_i,
  output logic [COLUMNS-1:0]                ib_ready_o,
  output logic [COLUMNS-1:0]                ib_present_o,
  output logic [STREAM_WIDTH-1:0]           host_data_o,
  output logic [$clog2(COLUMNS)-1:0]        host_col_o,
  output logic                              host_valid_o,
  input  logic                              host_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]       level_o,
  output logic [COUNT_WIDTH-1:0]            count_o,
  output logic                              idle_o
);

  localparam int unsigned COL_W = $clog2(COLUMNS);

  typedef struct packed {
    logic [COL_W-1:0]        col;
    logic [STREAM_WIDTH-1:0] data;
  } entry_t;

  logic [STREAM_WIDTH-1:0] w_col_data [COLUMNS];
  logic [COLUMNS-1:0]      w_cand;
  logic [COLUMNS-1:0]      w_grant;
  logic [COL_W-1:0]        w_grant_col;
  logic [COL_W-1:0]        w_sel;
  logic                    w_found;
  int unsigned             w_idx;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  entry_t                  w_push_entry;
  entry_t                  w_head;

  logic [COL_W-1:0]        r_rr;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_idle;

  for (genvar g = 0; g < COLUMNS; g++) begin : g_unpack
    assign w_col_data[g] = ib_data_i[g*STREAM_WIDTH +: STREAM_WIDTH];
  end

  // Ready is a pure function of local state and node-side inputs; host_ready_i never reaches it.
  always_comb begin
    w_cand      = (enable_i && !w_full && !flush_i) ? ib_valid_i : '0;
    w_grant     = '0;
    w_grant_col = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    w_sel       = '0;
    for (int unsigned i = 0; i < COLUMNS; i++) begin
      w_idx = 32'(r_rr) + i;
      if (w_idx >= COLUMNS) w_idx = w_idx - COLUMNS;
      w_sel = COL_W'(w_idx);
      if (!w_found && w_cand[w_sel]) begin
        w_found        = 1'b1;
        w_grant[w_sel] = 1'b1;
        w_grant_col    = w_sel;
      end
    end
  end

  assign ib_ready_o        = w_grant;
  assign ib_present_o      = {COLUMNS{enable_i}};
  assign w_push_entry.col  = w_grant_col;
  assign w_push_entry.data = w_col_data[w_grant_col];
  assign host_valid_o      = !w_empty;
  assign w_pop             = host_valid_o && host_ready_i;
  assign host_data_o       = w_head.data;
  assign host_col_o        = w_head.col;
  assign count_o           = r_count;
  assign idle_o            = r_idle;

  nx_egress_fifo #(
    .WIDTH (COL_W + STREAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_found),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr    <= '0;
      r_count <= '0;
      r_idle  <= 1'b0;
    end else begin
      if (w_found) begin
        r_rr <= COL_W'(nx_eg_wrap_inc(32'(w_grant_col), COLUMNS));
        if (r_count != {COUNT_WIDTH{1'b1}}) r_count <= r_count + 1'b1;
      end
      r_idle <= w_empty && !(|ib_valid_i);
    end
  end

endmodule
